// File: rtl/param_load_sched_if.sv
// Bundle between the host/DMA stream, the parameter buffers and the conv-layer bias port.
// master: host side plus conv layer; slave: param_load_sched.
interface param_load_sched_if #(
  parameter int DW = 16,
  parameter int AW = 10
);
  logic          start;
  logic          s_valid;
  logic [DW-1:0] s_data;
  logic          s_ready;
  logic [3:0]    wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    seg_done;
  logic          all_done;
  logic          bias_req;
  logic          bias_r_en;
  logic          bias_valid;
  logic          chk_err;

  modport master (
    output start, s_valid, s_data, bias_req,
    input  s_ready, wr_en, wr_addr, wr_data, seg_done, all_done, bias_r_en, bias_valid, chk_err
  );

  modport slave (
    input  start, s_valid, s_data, bias_req,
    output s_ready, wr_en, wr_addr, wr_data, seg_done, all_done, bias_r_en, bias_valid, chk_err
  );
endinterface

// File: rtl/param_load_sched.sv
// Loads CW, CB, LW, LB parameter segments from one word stream, then arbitrates conv bias reads.
// Optional trailing-checksum check is compiled in with PARAM_CHECKSUM_EN.
module param_load_sched #(
  parameter int DW     = 16,
  parameter int AW     = 10,
  parameter int CW_LEN = 288,
  parameter int CB_LEN = 32,
  parameter int LW_LEN = 640,
  parameter int LB_LEN = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  param_load_sched_if.slave prm_io
);
  localparam logic [AW-1:0] CW_LAST = AW'(CW_LEN - 1);
  localparam logic [AW-1:0] CB_LAST = AW'(CB_LEN - 1);
  localparam logic [AW-1:0] LW_LAST = AW'(LW_LEN - 1);
  localparam logic [AW-1:0] LB_LAST = AW'(LB_LEN - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_CW = 3'd1,
    ST_LOAD_CB = 3'd2,
    ST_LOAD_LW = 3'd3,
    ST_LOAD_LB = 3'd4,
`ifdef PARAM_CHECKSUM_EN
    ST_CHK     = 3'd5,
`endif
    ST_READY   = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          s_ready_q, s_ready_d;
  logic [3:0]    wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [DW-1:0] wr_data_q, wr_data_d;
  logic [3:0]    seg_done_q, seg_done_d;
  logic          all_done_q, all_done_d;
  logic          bias_r_en_q, bias_r_en_d;
  logic          bias_valid_q, bias_valid_d;

  logic          load_s, xfer_s, wr_s, seg_end_s, reload_s;
  logic [3:0]    seg_oh_s;
  logic [AW-1:0] last_s;

  // Decode which buffer the current state writes and its final address
  always_comb begin
    load_s   = 1'b1;
    seg_oh_s = 4'b0000;
    last_s   = {AW{1'b0}};
    case (state_q)
      ST_LOAD_CW: begin seg_oh_s = 4'b0001; last_s = CW_LAST; end
      ST_LOAD_CB: begin seg_oh_s = 4'b0010; last_s = CB_LAST; end
      ST_LOAD_LW: begin seg_oh_s = 4'b0100; last_s = LW_LAST; end
      ST_LOAD_LB: begin seg_oh_s = 4'b1000; last_s = LB_LAST; end
      default:    load_s = 1'b0;
    endcase
  end

  assign xfer_s    = prm_io.s_valid & s_ready_q;
  assign wr_s      = load_s & xfer_s;
  assign seg_end_s = wr_s & (cnt_q == last_s);
  assign reload_s  = (state_q == ST_READY) & prm_io.start;

  // State and word counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= {AW{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: a segment advances only on the transfer of its final word
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (prm_io.start) state_d = ST_LOAD_CW; else state_d = ST_IDLE;
      ST_LOAD_CW: if (seg_end_s)    state_d = ST_LOAD_CB; else state_d = ST_LOAD_CW;
      ST_LOAD_CB: if (seg_end_s)    state_d = ST_LOAD_LW; else state_d = ST_LOAD_CB;
      ST_LOAD_LW: if (seg_end_s)    state_d = ST_LOAD_LB; else state_d = ST_LOAD_LW;
`ifdef PARAM_CHECKSUM_EN
      ST_LOAD_LB: if (seg_end_s)    state_d = ST_CHK;     else state_d = ST_LOAD_LB;
      ST_CHK:     if (xfer_s)       state_d = ST_READY;   else state_d = ST_CHK;
`else
      ST_LOAD_LB: if (seg_end_s)    state_d = ST_READY;   else state_d = ST_LOAD_LB;
`endif
      ST_READY:   if (prm_io.start) state_d = ST_LOAD_CW; else state_d = ST_READY;
      default:    state_d = ST_IDLE;
    endcase
    if (seg_end_s) begin
      cnt_d = {AW{1'b0}};
    end else if (wr_s) begin
      cnt_d = cnt_q + {{(AW-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Output next values; a reload start outranks a bias request in the same cycle
  always_comb begin
    if (wr_s) begin
      wr_en_d   = seg_oh_s;
      wr_addr_d = cnt_q;
      wr_data_d = prm_io.s_data;
    end else begin
      wr_en_d   = 4'b0000;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
    end
    if (reload_s) begin
      seg_done_d = 4'b0000;
    end else if (seg_end_s) begin
      seg_done_d = seg_done_q | seg_oh_s;
    end else begin
      seg_done_d = seg_done_q;
    end
    s_ready_d = (state_d == ST_LOAD_CW) | (state_d == ST_LOAD_CB) |
                (state_d == ST_LOAD_LW) | (state_d == ST_LOAD_LB);
`ifdef PARAM_CHECKSUM_EN
    s_ready_d = s_ready_d | (state_d == ST_CHK);
`endif
    all_done_d   = (state_d == ST_READY);
    bias_r_en_d  = (state_q == ST_READY) & prm_io.bias_req & ~bias_r_en_q & ~prm_io.start;
    bias_valid_d = bias_r_en_q;
  end

  // Registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_ready_q    <= 1'b0;
      wr_en_q      <= 4'b0000;
      wr_addr_q    <= {AW{1'b0}};
      wr_data_q    <= {DW{1'b0}};
      seg_done_q   <= 4'b0000;
      all_done_q   <= 1'b0;
      bias_r_en_q  <= 1'b0;
      bias_valid_q <= 1'b0;
    end else begin
      s_ready_q    <= s_ready_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      seg_done_q   <= seg_done_d;
      all_done_q   <= all_done_d;
      bias_r_en_q  <= bias_r_en_d;
      bias_valid_q <= bias_valid_d;
    end
  end

`ifdef PARAM_CHECKSUM_EN
  logic [DW-1:0] sum_q, sum_d;
  logic          chk_err_q, chk_err_d;

  // Wrap-around sum of every written word; compared against the trailing word in CHK
  always_comb begin
    if (reload_s) begin
      sum_d     = {DW{1'b0}};
      chk_err_d = 1'b0;
    end else if (wr_s) begin
      sum_d     = sum_q + prm_io.s_data;
      chk_err_d = chk_err_q;
    end else if ((state_q == ST_CHK) && xfer_s) begin
      sum_d     = sum_q;
      chk_err_d = (prm_io.s_data != sum_q);
    end else begin
      sum_d     = sum_q;
      chk_err_d = chk_err_q;
    end
  end

  // Checksum registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q     <= {DW{1'b0}};
      chk_err_q <= 1'b0;
    end else begin
      sum_q     <= sum_d;
      chk_err_q <= chk_err_d;
    end
  end

  assign prm_io.chk_err = chk_err_q;
`else
  assign prm_io.chk_err = 1'b0;
`endif

  assign prm_io.s_ready    = s_ready_q;
  assign prm_io.wr_en      = wr_en_q;
  assign prm_io.wr_addr    = wr_addr_q;
  assign prm_io.wr_data    = wr_data_q;
  assign prm_io.seg_done   = seg_done_q;
  assign prm_io.all_done   = all_done_q;
  assign prm_io.bias_r_en  = bias_r_en_q;
  assign prm_io.bias_valid = bias_valid_q;
endmodule

// File: tb/tb_param_load_sched.sv
// Randomised bench for param_load_sched: expected writes come from the stream index and segment lengths.
module tb_param_load_sched;
  localparam int DW     = 16;
  localparam int AW     = 10;
  localparam int CW_LEN = 288;
  localparam int CB_LEN = 32;
  localparam int LW_LEN = 640;
  localparam int LB_LEN = 10;
  localparam int TOTAL  = CW_LEN + CB_LEN + LW_LEN + LB_LEN;
`ifdef PARAM_CHECKSUM_EN
  localparam int CHK_EN = 1;
`else
  localparam int CHK_EN = 0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_chk  = 0;

  param_load_sched_if #(.DW(DW), .AW(AW)) bus ();

  param_load_sched #(
    .DW(DW), .AW(AW), .CW_LEN(CW_LEN), .CB_LEN(CB_LEN), .LW_LEN(LW_LEN), .LB_LEN(LB_LEN)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .prm_io(bus)
  );

  always #5 clk = ~clk;

  logic [38:0] outs;
  assign outs = {bus.wr_en, bus.wr_addr, bus.wr_data, bus.seg_done, bus.all_done,
                 bus.s_ready, bus.bias_r_en, bus.bias_valid, bus.chk_err};

  function automatic int seg_of(input int i);
    if (i < CW_LEN) return 0;
    else if (i < CW_LEN + CB_LEN) return 1;
    else if (i < CW_LEN + CB_LEN + LW_LEN) return 2;
    else return 3;
  endfunction

  function automatic int base_of(input int s);
    case (s)
      0:       return 0;
      1:       return CW_LEN;
      2:       return CW_LEN + CB_LEN;
      default: return CW_LEN + CB_LEN + LW_LEN;
    endcase
  endfunction

  // Done flags once n words have been written
  function automatic logic [3:0] done_after(input int n);
    logic [3:0] d;
    d = 4'b0000;
    if (n >= CW_LEN) d[0] = 1'b1;
    if (n >= CW_LEN + CB_LEN) d[1] = 1'b1;
    if (n >= CW_LEN + CB_LEN + LW_LEN) d[2] = 1'b1;
    if (n >= TOTAL) d[3] = 1'b1;
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int errs;
    errs = 0;
    bus.start = 1'b0; bus.s_valid = 1'b0; bus.s_data = 16'h0000; bus.bias_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (outs !== 39'd0) $display("FAIL reset_outputs: got %h want 0", outs);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    bus.s_valid = 1'b1; bus.s_data = 16'h1234; bus.bias_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      if (bus.wr_en !== 4'b0000 || bus.s_ready !== 1'b0 || bus.bias_r_en !== 1'b0) errs++;
    end
    bus.s_valid = 1'b0; bus.bias_req = 1'b0;
    n_chk++;
    if (errs != 0) $display("FAIL idle_ignores_input: got %0d bad cycles want 0", errs);
    else n_pass++;
  endtask

  task automatic do_load(input string name, input int gap_pct, input bit send_start,
                         input int glitch_idx, input int abort_idx, input bit bad_sum);
    int          n, cyc, errs, cb_cnt, cb_first;
    bit          v;
    logic [DW-1:0] d, sum;
    logic [3:0]  want_en;
    logic        want_all;
    string       first;
    n = 0; cyc = 0; errs = 0; cb_cnt = 0; cb_first = -1; sum = '0; first = "none";
    bus.bias_req = 1'b0; bus.s_valid = 1'b0;
    if (send_start) begin
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      cyc = 1;
    end
    while (n < TOTAL && cyc < 20000) begin
      if (n == abort_idx) begin
        rst_n = 1'b0;
        #2;
        n_chk++;
        if (outs !== 39'd0) $display("FAIL %s_reset_outputs: got %h want 0", name, outs);
        else n_pass++;
        bus.s_valid = 1'b0; bus.start = 1'b0; bus.bias_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        n_chk++;
        if (bus.s_ready !== 1'b0 || bus.seg_done !== 4'b0000 || bus.all_done !== 1'b0)
          $display("FAIL %s_idle_after_reset: got ready=%b done=%h all=%b want 0/0/0",
                   name, bus.s_ready, bus.seg_done, bus.all_done);
        else n_pass++;
        return;
      end
      v = ($urandom_range(99) >= gap_pct);
      d = v ? DW'(n) : DW'($urandom);
      bus.s_valid  = v;
      bus.s_data   = d;
      bus.start    = (n == glitch_idx);
      bus.bias_req = ($urandom_range(1) == 1);
      if (bus.s_ready !== 1'b1) begin
        errs++;
        if (first == "none") first = $sformatf("s_ready=%b at word %0d", bus.s_ready, n);
      end
      step();
      cyc++;
      want_en = 4'b0000;
      if (v) begin
        want_en = 4'b0001 << seg_of(n);
        if (bus.wr_addr !== AW'(n - base_of(seg_of(n))) || bus.wr_data !== DW'(n)) begin
          errs++;
          if (first == "none")
            first = $sformatf("word %0d addr=%0d data=%0d want addr=%0d data=%0d",
                              n, bus.wr_addr, bus.wr_data, n - base_of(seg_of(n)), n);
        end
        sum = sum + DW'(n);
        n++;
      end
      if (bus.wr_en[1] === 1'b1) begin
        if (cb_first < 0) cb_first = int'(bus.wr_data);
        cb_cnt++;
      end
      want_all = (CHK_EN == 0) && (n == TOTAL);
      if (bus.wr_en !== want_en || bus.seg_done !== done_after(n) ||
          bus.all_done !== want_all || bus.bias_r_en !== 1'b0) begin
        errs++;
        if (first == "none")
          first = $sformatf("after %0d words wr_en=%b seg_done=%h all=%b r_en=%b want %b/%h/%b/0",
                            n, bus.wr_en, bus.seg_done, bus.all_done, bus.bias_r_en,
                            want_en, done_after(n), want_all);
      end
    end
    bus.start = 1'b0; bus.bias_req = 1'b0;
`ifdef PARAM_CHECKSUM_EN
    bus.s_valid = 1'b1;
    bus.s_data  = sum + DW'(bad_sum);
    step();
    cyc++;
    n_chk++;
    if (bus.chk_err !== bad_sum || bus.all_done !== 1'b1 || bus.wr_en !== 4'b0000)
      $display("FAIL %s_checksum: got chk_err=%b all=%b wr_en=%b want %b/1/0",
               name, bus.chk_err, bus.all_done, bus.wr_en, bad_sum);
    else n_pass++;
`endif
    bus.s_valid = 1'b0;
    n_chk++;
    if (errs != 0 || n != TOTAL)
      $display("FAIL %s_writes: got %0d errors %0d words want 0 errors %0d words, first: %s",
               name, errs, n, TOTAL, first);
    else n_pass++;
    n_chk++;
    if (cb_cnt != CB_LEN || cb_first != CW_LEN)
      $display("FAIL %s_cb_segment: got %0d writes first=%0d want %0d first=%0d",
               name, cb_cnt, cb_first, CB_LEN, CW_LEN);
    else n_pass++;
    if (gap_pct == 0 && send_start) begin
      n_chk++;
      if (cyc != TOTAL + 1 + CHK_EN)
        $display("FAIL %s_load_cycles: got %0d want %0d", name, cyc, TOTAL + 1 + CHK_EN);
      else n_pass++;
    end
    n_chk++;
    if (bus.all_done !== 1'b1 || bus.seg_done !== 4'hF || bus.s_ready !== 1'b0)
      $display("FAIL %s_final: got all=%b seg_done=%h ready=%b want 1/F/0",
               name, bus.all_done, bus.seg_done, bus.s_ready);
    else n_pass++;
  endtask

  task automatic test_bias_held();
    logic [7:0] ren, val;
    ren = 8'h00; val = 8'h00;
    bus.bias_req = 1'b0;
    step();
    bus.bias_req = 1'b1;
    for (int j = 0; j < 8; j++) begin
      if (j == 6) bus.bias_req = 1'b0;
      step();
      ren[j] = bus.bias_r_en;
      val[j] = bus.bias_valid;
    end
    n_chk++;
    if (ren !== 8'b0001_0101) $display("FAIL bias_held_r_en: got %b want 00010101", ren);
    else n_pass++;
    n_chk++;
    if (val !== 8'b0010_1010) $display("FAIL bias_held_valid: got %b want 00101010", val);
    else n_pass++;
  endtask

  task automatic test_bias_random();
    bit busy, req, exp_r, exp_v;
    int errs;
    busy = 1'b0; errs = 0;
    for (int j = 0; j < 40; j++) begin
      req = ($urandom_range(1) == 1);
      bus.bias_req = req;
      step();
      exp_r = req && !busy;
      exp_v = busy;
      if (bus.bias_r_en !== exp_r || bus.bias_valid !== exp_v) errs++;
      busy = exp_r;
    end
    bus.bias_req = 1'b0;
    n_chk++;
    if (errs != 0) $display("FAIL bias_random: got %0d bad cycles want 0", errs);
    else n_pass++;
  endtask

  task automatic test_reload_inflight();
    bus.bias_req = 1'b0;
    step();
    step();
    bus.bias_req = 1'b1;
    step();
    n_chk++;
    if (bus.bias_r_en !== 1'b1) $display("FAIL reload_pre_read: got r_en=%b want 1", bus.bias_r_en);
    else n_pass++;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0; bus.bias_req = 1'b0;
    n_chk++;
    if ({bus.bias_r_en, bus.bias_valid, bus.all_done, bus.seg_done, bus.s_ready, bus.chk_err} !== 9'b0_1_0_0000_1_0)
      $display("FAIL reload_clear: got r_en=%b valid=%b all=%b seg=%h ready=%b chk=%b want 0/1/0/0/1/0",
               bus.bias_r_en, bus.bias_valid, bus.all_done, bus.seg_done, bus.s_ready, bus.chk_err);
    else n_pass++;
    do_load("reload", 0, 1'b0, -1, -1, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    do_load("full_load", 0, 1'b1, -1, -1, 1'b0);
    test_bias_held();
    test_bias_random();
    do_load("gap_load", 50, 1'b1, CW_LEN + CB_LEN + 100, -1, 1'b1);
    test_reload_inflight();
    do_load("abort", 0, 1'b1, -1, CW_LEN + 15, 1'b0);
    do_load("after_reset", 10, 1'b1, -1, -1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/param_load_sched.md
# param_load_sched

Sequences loading of all network parameters from a single 16-bit input stream into the conv weight, conv bias, linear weight and linear bias buffers, in a fixed order. It drives each buffer's write strobe and address. It raises per-segment done flags and a global `all_done`. After loading, it arbitrates conv-layer requests for the registered bias read (`r_en`) of the conv bias buffer and returns a matching valid strobe. It sits between the host/DMA input port and the parameter buffers.

## Interface
- `DW`, 16, parameter word width.
- `AW`, 10, write address width; every segment length ≤ 2^AW.
- `CW_LEN`, 288, conv weight words.
- `CB_LEN`, 32, conv bias words.
- `LW_LEN`, 640, linear weight words.
- `LB_LEN`, 10, linear bias words.

Reset `rst_n`, asynchronous, active-low; clock `clk`.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  single-cycle pulse; begins a load sequence.
- `s_valid`  in  1  input word valid.
- `s_data`  in  DW  input word.
- `s_ready`  out  1  block accepts a word this cycle.
- `wr_en`  out  4  one-hot write strobe: bit0 CW, bit1 CB, bit2 LW, bit3 LB.
- `wr_addr`  out  AW  word index within the current segment.
- `wr_data`  out  DW  registered copy of the accepted word.
- `seg_done`  out  4  sticky per-segment done flags, same bit order as `wr_en`.
- `all_done`  out  1  all segments loaded (and checksum checked when enabled).
- `bias_req`  in  1  conv-layer level request for the bias vector.
- `bias_r_en`  out  1  read strobe to the conv bias buffer.
- `bias_valid`  out  1  bias vector on the buffer output is valid.
- `chk_err`  out  1  checksum mismatch; constant 0 when the feature is compiled out.

## Operation
- States: IDLE, LOAD_CW, LOAD_CB, LOAD_LW, LOAD_LB, CHK (only with the macro), READY.
- IDLE → LOAD_CW on `start`.
- READY → LOAD_CW on `start` (reload). The reload clears `seg_done`, `all_done` and `chk_err`. `start` in any other state is ignored.
- A transfer occurs when `s_valid && s_ready`.
- `s_ready` = 1 exactly in the LOAD_* and CHK states.
- On each transfer in LOAD_x, `cnt` (AW bits) selects the address. `cnt` increments; when `cnt == x_LEN-1` it clears to 0, `seg_done[x]` sets, and the state advances: CW→CB→LW→LB→(CHK|READY).
- A transfer in CHK does not write. It compares the word with the accumulated sum, sets `chk_err` on mismatch, then goes to READY.
- No transfer in a cycle means the state and `cnt` hold; wait cycles are allowed anywhere in the stream.
- `all_done` = 1 in READY.
- Bias arbitration is active only in READY. If `bias_req`=1 and no read is in flight, `bias_r_en` pulses for 1 cycle. `bias_valid` pulses for 1 cycle on the following cycle.
- At most one read is in flight. A held `bias_req` produces one `bias_r_en` every 2 cycles.
- `bias_req` outside READY is ignored (no strobe).
- A reload `start` in READY takes precedence over `bias_req` in the same cycle. Any in-flight read still completes with its `bias_valid`.

## Timing
- Reset values: all outputs 0, state IDLE, `cnt` 0, sum 0.
- Write latency: `wr_en`, `wr_addr` and `wr_data` are registered and valid 1 cycle after the transfer.
- `wr_en` is high for exactly 1 cycle per transfer.
- `seg_done[x]` rises in the same cycle as the final `wr_en[x]` of segment x.
- `all_done` rises the cycle after the last LB transfer (or after the CHK transfer).
- Minimum load time: CW_LEN+CB_LEN+LW_LEN+LB_LEN cycles with `s_valid` held high, +1 cycle with the checksum enabled.
- `rst_n` low mid-load returns the block to IDLE immediately. Partial buffer contents are abandoned, and all flags clear.
- `bias_r_en` → `bias_valid` latency: 1 cycle, matching the conv bias buffer's registered output.

## Configuration
- `PARAM_CHECKSUM_EN` defined:
  - A DW-bit wrap-around (mod 2^DW) sum accumulates every data word of all four segments.
  - The CHK state consumes one extra trailing word, the expected sum.
  - `chk_err` sets on mismatch and remains set until the next `start` or reset. `all_done` still asserts.
- `PARAM_CHECKSUM_EN` undefined:
  - No CHK state and no accumulator.
  - LOAD_LB goes directly to READY.
  - `chk_err` is tied to 0.

## Test plan
- Full load with `s_valid` held high and `s_data` = running index 0..969:
  - `wr_en[1]` is high for addresses 0..31 carrying data 288..319.
  - `seg_done` steps through 1, 3, 7, F.
  - `all_done` = 1 at cycle 971.
- Random `s_valid` gaps (50%) with the same data: the writes are identical in order and address, with no duplicated or dropped `wr_en` pulse.
- In READY, `bias_req` held high for 6 cycles: `bias_r_en` pulses at cycles 0, 2 and 4, and `bias_valid` pulses at 1, 3 and 5. `bias_req` during LOAD_CB produces no `bias_r_en`.
- `start` pulsed during LOAD_LW is ignored. A `start` pulse in READY clears `seg_done` to 0 and restarts at CW address 0.
- `rst_n` pulled low at CB address 15: all outputs 0 and state IDLE. A new `start` and full stream completes normally.
- With `PARAM_CHECKSUM_EN`:
  - Correct trailing sum → `chk_err` = 0.
  - Trailing sum+1 → `chk_err` = 1 and `all_done` = 1; the next `start` clears `chk_err`.
